job_dispatcher: RTL
===================

JOB_DISPATCHER -- requirements
Module: job_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-pair FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 255, done-wait limit in cycles (used only under REQ-030).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have port op_valid  in  1  software offers an operand pair.
REQ-006 SHALL have port op_a  in  16  first operand.
REQ-007 SHALL have port op_b  in  16  second operand.
REQ-008 SHALL have port op_ready  out  1  FIFO not full.
REQ-009 SHALL have port acc_start  out  1  one-cycle start pulse to accelerator.
REQ-010 SHALL have port acc_inp1  out  16  registered operand to accelerator.
REQ-011 SHALL have port acc_inp2  out  16  registered operand to accelerator.
REQ-012 SHALL have port acc_done  in  1  accelerator completion.
REQ-013 SHALL have port acc_out  in  16  accelerator result, valid with acc_done.
REQ-014 SHALL have port res_valid  out  1  result held for software.
REQ-015 SHALL have port res_data  out  16  captured result.
REQ-016 SHALL have port res_err  out  1  result produced by timeout.
REQ-017 SHALL have port res_ready  in  1  software accepts result.

Function
REQ-018 SHALL push {op_a,op_b} on op_valid&&op_ready; op_ready=0 exactly when FIFO holds DEPTH entries.
REQ-019 SHALL run FSM IDLE->LOAD->START->WAIT->OUT->IDLE.
- IDLE: if FIFO non-empty, pop head into acc_inp1/acc_inp2, go LOAD.
- LOAD: one cycle, operands stable.
- START: acc_start=1 this cycle only, go WAIT.
- WAIT: on acc_done, capture acc_out into res_data, res_err=0, go OUT.
- OUT: res_valid=1; on res_ready, go IDLE.
REQ-020 SHALL hold acc_inp1/acc_inp2 constant from LOAD until the next pop.
REQ-021 SHALL ignore acc_done in every state except WAIT, including the START cycle.
REQ-022 SHALL hold res_data/res_err stable while res_valid=1 and res_ready=0.
REQ-023 SHALL give push-to-acc_start latency of 3 cycles when FSM is IDLE and FIFO empty (push, IDLE pop, LOAD, START).
REQ-024 SHALL allow simultaneous push and pop when full; simultaneous push/pop on empty FIFO SHALL NOT pop that cycle.
REQ-025 SHALL wrap FIFO pointers modulo DEPTH with an extra occupancy bit.
REQ-026 SHALL accept pushes in every FSM state.

Reset
REQ-027 SHALL, on rst=0, asynchronously clear: FSM to IDLE, FIFO empty, acc_start=0, acc_inp1=acc_inp2=0, res_valid=0, res_data=0, res_err=0, op_ready=1 after release.
REQ-028 SHALL discard any in-flight job and queued operands on reset mid-operation.
REQ-029 SHALL not issue acc_start earlier than the second rising edge after rst release.

Configuration
REQ-030 SHALL, with DISPATCH_TIMEOUT_EN defined, count WAIT cycles; at TIMEOUT without acc_done go OUT with res_data=16'hFFFF, res_err=1.
REQ-031 SHALL, without DISPATCH_TIMEOUT_EN, have no counter, wait indefinitely, res_err tied 0.

Structure
REQ-032 SHALL place DATA_W=16, state typedef (IDLE,LOAD,START,WAIT,OUT) and ERR_RESULT=16'hFFFF in package dispatch_pkg.
REQ-033 SHALL implement the operand buffer as sub-module op_fifo (width 32, DEPTH entries).

Verification
REQ-034 Push {2000h,2000h}, model returns 0800h 4 cycles after start -> one acc_start pulse, inp1=inp2=2000h, res_valid with res_data=0800h.
REQ-035 Push 5 pairs with model stalled, DEPTH=4 -> op_ready=0 after 4th pop-adjusted entry, no pair lost, results in push order.
REQ-036 acc_done pulsed during LOAD/START -> ignored, FSM stays until genuine done in WAIT.
REQ-037 res_ready held 0 for 10 cycles -> res_data stable, no new acc_start issued.
REQ-038 rst asserted during WAIT with 2 queued pairs -> all outputs 0, FIFO empty, no acc_start after release until new push.
REQ-039 DISPATCH_TIMEOUT_EN, TIMEOUT=255, model never asserts done -> after 255 WAIT cycles res_valid=1, res_data=FFFFh, res_err=1.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and constants for the job dispatcher.
// Operand pairs travel as {a, b}; ERR_RESULT marks a timed-out job.
package dispatch_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] ERR_RESULT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    OUT
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/op_fifo.sv
// Operand-pair FIFO, DEPTH entries (power of two).
// Pointers carry one extra wrap bit to tell full from empty.
module op_fifo
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // an empty FIFO never pops, a full one accepts only alongside a pop
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // pointer advance, wrapping modulo 2*DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // storage, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/job_dispatcher.sv
// Feeds queued operand pairs to an accelerator, one job at a time.
// Optional done-wait timeout: define DISPATCH_TIMEOUT_EN.
module job_dispatcher
  import dispatch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        op_ready,
  output logic        acc_start,
  output logic [15:0] acc_inp1,
  output logic [15:0] acc_inp2,
  input  logic        acc_done,
  input  logic [15:0] acc_out,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_err,
  input  logic        res_ready
);

  state_e      state_q, state_d;
  logic [15:0] inp1_q, inp1_d;
  logic [15:0] inp2_q, inp2_d;
  logic [15:0] res_data_q, res_data_d;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  op_pair_t    fifo_wdata;
  op_pair_t    fifo_head;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  // TIMEOUT has no hardware in this build
  if (TIMEOUT < 1) begin : g_no_timeout
  end
`endif

  assign op_ready   = !fifo_full;
  assign fifo_push  = op_valid && op_ready;
  assign fifo_wdata = '{a: op_a, b: op_b};

  op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign acc_inp1  = inp1_q;
  assign acc_inp2  = inp2_q;
  assign res_valid = (state_q == OUT);
  assign res_data  = res_data_q;

  // job sequencing; acc_done only matters in WAIT
  always_comb begin
    state_d    = state_q;
    inp1_d     = inp1_q;
    inp2_d     = inp2_q;
    res_data_d = res_data_q;
    fifo_pop   = 1'b0;
    acc_start  = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          inp1_d   = fifo_head.a;
          inp2_d   = fifo_head.b;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        acc_start = 1'b1;
        state_d   = WAIT;
`ifdef DISPATCH_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      WAIT: begin
        if (acc_done) begin
          res_data_d = acc_out;
          state_d    = OUT;
`ifdef DISPATCH_TIMEOUT_EN
          err_d      = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_data_d = ERR_RESULT;
          err_d      = 1'b1;
          state_d    = OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // operand and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inp1_q     <= '0;
      inp2_q     <= '0;
      res_data_q <= '0;
    end else begin
      inp1_q     <= inp1_d;
      inp2_q     <= inp2_d;
      res_data_q <= res_data_d;
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  // timeout counter and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

endmodule
